// File: rtl/lc3_wb_pkg.sv
// Shared types and helpers for the LC3 writeback stage.
// Holds the writeback source encoding, PSR bit positions and the N/Z/P flag helper.
// Used by lc3_writeback_unit and lc3_wb_regfile.
package lc3_wb_pkg;

   // Writeback result source, as presented on W_Control.
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_PC   = 2'd1,
      WB_MEM  = 2'd2,
      WB_RSVD = 2'd3
   } wb_src_e;

   // Bit positions inside the 3-bit {N,Z,P} psr vector.
   localparam int PSR_N = 2;
   localparam int PSR_Z = 1;
   localparam int PSR_P = 0;

   // Widest data path the flag helper accepts; callers zero-extend into it.
   localparam int NZP_MAX_W = 64;

   // Condition codes for a DATA_W-wide value.  The value is passed
   // zero-extended to NZP_MAX_W bits together with its real width, so a single
   // package function serves every DATA_W up to NZP_MAX_W.  The sign bit is
   // located with a mask so no variable bit-select is needed.
   function automatic logic [2:0] nzp_f(input logic [NZP_MAX_W-1:0] data,
                                        input int unsigned          data_w);
      logic [NZP_MAX_W-1:0] sign_mask;
      logic [2:0]           flags;
      sign_mask    = NZP_MAX_W'(1) << (data_w - 1);
      flags        = '0;
      flags[PSR_N] = |(data & sign_mask);
      flags[PSR_Z] = (data == '0);
      // Exactly one flag is ever set: positive means neither negative nor zero.
      flags[PSR_P] = ~flags[PSR_N] & ~flags[PSR_Z];
      return flags;
   endfunction

endpackage

// File: rtl/lc3_wb_regfile.sv
// Register file: NUM_REGS x DATA_W storage, one write port, RD_PORTS registered read ports.
// Latency: 1 cycle from raddr_i to rdata_o; writes land at the clock edge.
// Backpressure: none, a write and all reads are accepted every cycle.
//
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (clears storage and read data)
//   we_i          - commit wdata_i into entry waddr_i at this edge
//   waddr_i       - write index
//   wdata_i       - write data
//   raddr_i       - packed read indices, slice k addresses port k
//   rdata_o       - packed registered read data, slice k belongs to port k
//
// Build option: LC3_WB_BYPASS_EN makes a read that hits the entry being
// written this cycle return the new data (write-through).  Without it the
// read returns the value held before the write (read-before-write).
module lc3_wb_regfile
   import lc3_wb_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int NUM_REGS = 8,
   parameter  int RD_PORTS = 2,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         we_i,
   input  logic [ADDR_W-1:0]            waddr_i,
   input  logic [DATA_W-1:0]            wdata_i,
   input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
   output logic [RD_PORTS*DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0]          mem_q [NUM_REGS];
   logic [RD_PORTS*DATA_W-1:0] rdata_q;
   logic [RD_PORTS*DATA_W-1:0] rdata_d;

   // Next read data per port.  The array lookup always sees the pre-write
   // contents because storage only changes at the edge.
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr_i[k*ADDR_W +: ADDR_W];

      always_comb begin
         rdata_d[k*DATA_W +: DATA_W] = mem_q[ra];
`ifdef LC3_WB_BYPASS_EN
         if (we_i && (ra == waddr_i)) begin
            rdata_d[k*DATA_W +: DATA_W] = wdata_i;
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
         rdata_q <= '0;
      end else begin
         if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
         end
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_writeback_unit.sv
// LC3 writeback stage: result-source mux, register file, PSR {N,Z,P} and illegal-source flag.
// Latency: 1 cycle for reads (sr -> VSR), writes and psr update at the commit edge, wb_err the cycle after.
// Backpressure: none, one write attempt and all reads are accepted every cycle.
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   enable_writeback  - qualifies a write this cycle
//   W_Control         - source select: 0 aluout, 1 pcout, 2 memout, 3 reserved (flagged on wb_err)
//   aluout/pcout/memout - candidate write data
//   dr                - destination register index
//   sr                - packed source indices, slice k addresses read port k
//   VSR               - packed registered read data, slice 0 is VSR1, slice 1 is VSR2
//   psr               - {N,Z,P} of the last committed write
//   wb_err            - one-cycle pulse after a write attempt with the reserved source
//
// Build option: LC3_WB_BYPASS_EN forwards committed write data to read ports
// addressing dr in the same cycle.  Register contents and psr do not depend on it.
module lc3_writeback_unit
   import lc3_wb_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int NUM_REGS = 8,
   parameter  int RD_PORTS = 2,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         enable_writeback,
   input  logic [1:0]                   W_Control,
   input  logic [DATA_W-1:0]            aluout,
   input  logic [DATA_W-1:0]            pcout,
   input  logic [DATA_W-1:0]            memout,
   input  logic [ADDR_W-1:0]            dr,
   input  logic [RD_PORTS*ADDR_W-1:0]   sr,
   output logic [RD_PORTS*DATA_W-1:0]   VSR,
   output logic [2:0]                   psr,
   output logic                         wb_err
);

   wb_src_e           src;
   logic [DATA_W-1:0] wdata;
   logic              commit;
   logic [2:0]        psr_d,    psr_q;
   logic              wb_err_d, wb_err_q;

   assign src = wb_src_e'(W_Control);

   // Source mux.  The reserved code never commits, so its data value is
   // irrelevant; aluout is returned just to keep the mux fully specified.
   always_comb begin
      wdata = aluout;
      unique case (src)
         WB_ALU:  wdata = aluout;
         WB_PC:   wdata = pcout;
         WB_MEM:  wdata = memout;
         WB_RSVD: wdata = aluout;
         default: wdata = aluout;
      endcase
   end

   assign commit = enable_writeback && (src != WB_RSVD);

   always_comb begin
      psr_d    = psr_q;
      wb_err_d = 1'b0;
      if (commit) begin
         psr_d = nzp_f(NZP_MAX_W'(wdata), DATA_W);
      end
      if (enable_writeback && (src == WB_RSVD)) begin
         wb_err_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         psr_q    <= 3'b000;
         wb_err_q <= 1'b0;
      end else begin
         psr_q    <= psr_d;
         wb_err_q <= wb_err_d;
      end
   end

   lc3_wb_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .RD_PORTS (RD_PORTS)
   ) u_regfile (
      .clock   (clock),
      .reset   (reset),
      .we_i    (commit),
      .waddr_i (dr),
      .wdata_i (wdata),
      .raddr_i (sr),
      .rdata_o (VSR)
   );

   assign psr    = psr_q;
   assign wb_err = wb_err_q;

endmodule

// File: tb/tb_lc3_writeback_unit.sv
`timescale 1ns/1ps
module tb_lc3_writeback_unit;

   // Instance 0: default parameters.  Instance 1: DATA_W=32, NUM_REGS=16, RD_PORTS=3.
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset0, en0;
   logic [1:0]  wc0;
   logic [15:0] alu0, pc0, mem0;
   logic [2:0]  dr0;
   logic [5:0]  sr0;
   logic [31:0] vsr0;
   logic [2:0]  psr0;
   logic        err0;

   logic        reset1, en1;
   logic [1:0]  wc1;
   logic [31:0] alu1, pc1, mem1;
   logic [3:0]  dr1;
   logic [11:0] sr1;
   logic [95:0] vsr1;
   logic [2:0]  psr1;
   logic        err1;

   lc3_writeback_unit dut0 (
      .clock(clock), .reset(reset0), .enable_writeback(en0), .W_Control(wc0),
      .aluout(alu0), .pcout(pc0), .memout(mem0), .dr(dr0), .sr(sr0),
      .VSR(vsr0), .psr(psr0), .wb_err(err0)
   );

   lc3_writeback_unit #(.DATA_W(32), .NUM_REGS(16), .RD_PORTS(3)) dut1 (
      .clock(clock), .reset(reset1), .enable_writeback(en1), .W_Control(wc1),
      .aluout(alu1), .pcout(pc1), .memout(mem1), .dr(dr1), .sr(sr1),
      .VSR(vsr1), .psr(psr1), .wb_err(err1)
   );

   typedef struct packed {
      logic             rst;
      logic             en;
      logic [1:0]       wc;
      logic [31:0]      alu;
      logic [31:0]      pc;
      logic [31:0]      mem;
      logic [3:0]       dr;
      logic [2:0][3:0]  sr;
   } stim_t;

   typedef struct packed {
      logic [2:0][31:0] vsr;
      logic [2:0]       psr;
      logic             err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   bit   done0 = 0, done1 = 0;

   // ---------------- reference model ----------------
   logic [31:0] mreg [2][16];
   logic [2:0]  mpsr [2];

   // Flags from the numeric value: zero, negative in W-bit two's complement, else positive.
   function automatic logic [2:0] nzp_ref(input longint unsigned v, input int w);
      longint unsigned half;
      half = longint'(1) << (w - 1);
      if (v == 0)     return 3'b010;
      if (v >= half)  return 3'b100;
      return 3'b001;
   endfunction

   task automatic model_step(input int i, input stim_t s, output exp_t e);
      int              w, n, p, d, idx;
      longint unsigned mask, wd;
      bit              commit, bypass;
      w    = (i == 0) ? 16 : 32;
      n    = (i == 0) ? 8  : 16;
      p    = (i == 0) ? 2  : 3;
      mask = (longint'(1) << w) - 1;
      bypass = 0;
`ifdef LC3_WB_BYPASS_EN
      bypass = 1;
`endif
      e = '0;
      if (s.rst) begin
         for (int r = 0; r < 16; r++) mreg[i][r] = '0;
         mpsr[i] = 3'b000;
         return;
      end
      case (s.wc)
         2'd0:    wd = longint'(s.alu) & mask;
         2'd1:    wd = longint'(s.pc)  & mask;
         default: wd = longint'(s.mem) & mask;
      endcase
      commit = s.en && (s.wc != 2'd3);
      d = int'(s.dr) % n;
      for (int k = 0; k < p; k++) begin
         idx = int'(s.sr[k]) % n;
         e.vsr[k] = mreg[i][idx];
         if (bypass && commit && idx == d) e.vsr[k] = wd[31:0];
      end
      if (commit) begin
         mreg[i][d] = wd[31:0];
         mpsr[i]    = nzp_ref(wd, w);
      end
      e.psr = mpsr[i];
      e.err = s.en && (s.wc == 2'd3);
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic stim_t mk(input bit rst, input bit en, input logic [1:0] wc,
                                input logic [31:0] alu, input logic [31:0] pc,
                                input logic [31:0] mem, input int dr,
                                input int s0, input int s1, input int s2);
      stim_t s;
      s.rst = rst; s.en = en; s.wc = wc;
      s.alu = alu; s.pc = pc; s.mem = mem;
      s.dr = 4'(dr);
      s.sr[0] = 4'(s0); s.sr[1] = 4'(s1); s.sr[2] = 4'(s2);
      return s;
   endfunction

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 3))
         0:       return 32'h0;
         1:       return 32'h8000_0000 | $urandom;
         default: return $urandom;
      endcase
   endfunction

   function automatic stim_t rnd(input int n);
      stim_t s;
      int    d;
      d = $urandom_range(0, n - 1);
      s = mk($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
             2'($urandom_range(0, 3)), rval(), rval(), rval(), d, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         s.sr[k] = 4'(($urandom_range(0, 1) == 0) ? d : $urandom_range(0, n - 1));
      return s;
   endfunction

   task automatic drive0(input stim_t s);
      exp_t e;
      reset0 = s.rst; en0 = s.en; wc0 = s.wc;
      alu0 = s.alu[15:0]; pc0 = s.pc[15:0]; mem0 = s.mem[15:0];
      dr0 = s.dr[2:0];
      sr0 = {s.sr[1][2:0], s.sr[0][2:0]};
      model_step(0, s, e);
      q0.push_back(e);
      @(negedge clock);
   endtask

   task automatic drive1(input stim_t s);
      exp_t e;
      reset1 = s.rst; en1 = s.en; wc1 = s.wc;
      alu1 = s.alu; pc1 = s.pc; mem1 = s.mem;
      dr1 = s.dr;
      sr1 = {s.sr[2], s.sr[1], s.sr[0]};
      model_step(1, s, e);
      q1.push_back(e);
      @(negedge clock);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   initial begin
      reset0 = 1'b1; en0 = 0; wc0 = 0; alu0 = 0; pc0 = 0; mem0 = 0; dr0 = 0; sr0 = 0;
      @(negedge clock);
      drive0(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive0(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive0(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));                  // reset-then-read
      drive0(mk(0, 1, 0, 32'h8001, 0, 0, 3, 0, 0, 0));           // ALU negative
      drive0(mk(0, 1, 0, 32'h0000, 0, 0, 4, 3, 0, 0));           // zero, read r3
      drive0(mk(0, 1, 2, 32'h1234, 0, 32'h0005, 6, 4, 3, 0));    // mem positive
      drive0(mk(0, 1, 1, 0, 32'h1111, 0, 5, 0, 0, 0));           // reg5 = 1111
      drive0(mk(0, 1, 0, 32'h2222, 0, 0, 5, 5, 5, 0));           // hazard
      drive0(mk(0, 0, 0, 0, 0, 0, 0, 5, 5, 0));                  // re-read
      drive0(mk(0, 1, 3, 0, 32'hFFFF, 0, 2, 2, 6, 0));           // illegal source
      drive0(mk(0, 0, 0, 0, 0, 0, 0, 2, 6, 0));
      drive0(mk(0, 0, 0, 32'h7777, 0, 0, 1, 1, 0, 0));           // gated write
      drive0(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0));
      drive0(mk(1, 1, 0, 32'h4321, 0, 0, 6, 6, 0, 0));           // reset vs write
      drive0(mk(0, 0, 0, 0, 0, 0, 0, 6, 5, 0));
      for (int c = 0; c < 400; c++) drive0(rnd(8));
      done0 = 1;
   end

   initial begin
      reset1 = 1'b1; en1 = 0; wc1 = 0; alu1 = 0; pc1 = 0; mem1 = 0; dr1 = 0; sr1 = 0;
      @(negedge clock);
      drive1(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive1(mk(0, 1, 0, 32'h8000_0000, 0, 0, 15, 15, 15, 15));
      drive1(mk(0, 0, 0, 0, 0, 0, 0, 15, 15, 15));
      for (int c = 0; c < 300; c++) drive1(rnd(16));
      done1 = 1;
   end

   // ---------------- monitors ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            for (int k = 0; k < 2; k++)
               chk($sformatf("i0.VSR%0d", k + 1), {16'h0, vsr0[k*16 +: 16]}, {16'h0, e.vsr[k][15:0]});
            chk("i0.psr", {29'h0, psr0}, {29'h0, e.psr});
            chk("i0.wb_err", {31'h0, err0}, {31'h0, e.err});
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q1.size() > 0) begin
            e = q1.pop_front();
            for (int k = 0; k < 3; k++)
               chk($sformatf("i1.VSR%0d", k + 1), vsr1[k*32 +: 32], e.vsr[k]);
            chk("i1.psr", {29'h0, psr1}, {29'h0, e.psr});
            chk("i1.wb_err", {31'h0, err1}, {31'h0, e.err});
         end
      end
   end

   // ---------------- end of run ----------------
   initial begin
      fork
         wait (done0 && done1);
         #200000;
      join_any
      disable fork;
      if (!(done0 && done1)) begin
         checks++;
         errors++;
         $display("FAIL timeout: drivers did not complete");
      end
      repeat (2) @(negedge clock);
      chk("i0.queue_drained", q0.size(), 0);
      chk("i1.queue_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
